// File: rtl/mult_pkg.sv
// Shared definitions for the multiply/dot-product wrapper and its tree multiplier.
// Latency: n/a (types, defaults and width helper only).
// Backpressure: n/a.
package mult_pkg;

    localparam int DEF_W   = 4;
    localparam int DEF_LEN = 4;

    // ACC collects products of the current vector, DONE holds the finished result.
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Worst case sum is LEN*(2^W-1)^2, which always fits in 2W + clog2(LEN) bits.
    function automatic int acc_width(input int w, input int len);
        return 2 * w + $clog2(len);
    endfunction

endpackage

// File: rtl/mult_tree.sv
// Combinational W x W unsigned tree multiplier (partial products summed pairwise).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the product follows the operands.
module mult_tree #(
    parameter int W = 4
) (
    input  logic [W-1:0]   i_x,
    input  logic [W-1:0]   i_y,
    output logic [2*W-1:0] o_p
);

    // Padded to a power of two so the reduction tree is balanced.
    localparam int NP = 1 << $clog2(W);

    // Build shifted partial products, then fold them in log2(NP) adder levels.
    always_comb begin
        logic [2*W-1:0] w_pp [NP];
        for (int i = 0; i < NP; i++) begin
            w_pp[i] = '0;
        end
        for (int i = 0; i < W; i++) begin
            if (i_y[i]) begin
                w_pp[i] = {{W{1'b0}}, i_x} << i;
            end
        end
        for (int s = 1; s < NP; s = s * 2) begin
            for (int i = 0; i + s < NP; i = i + 2 * s) begin
                w_pp[i] = w_pp[i] + w_pp[i + s];
            end
        end
        o_p = w_pp[0];
    end

endmodule

// File: rtl/mult_dot_acc.sv
// Registers operand pairs onto an external multiplier and accumulates products into one dot-product result per vector.
// Latency: last element accepted at edge k gives out_valid after edge k+1; 1 element/cycle within a vector.
// Backpressure: in_ready drops once a last element is taken and stays low until the result handshakes on out_valid/out_ready.
module mult_dot_acc
    import mult_pkg::*;
#(
    parameter  int W     = DEF_W,
    parameter  int LEN   = DEF_LEN,
    localparam int ACC_W = acc_width(W, LEN),
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_last,
    output logic [W-1:0]     mul_x,
    output logic [W-1:0]     mul_y,
    input  logic [2*W-1:0]   mul_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1_v;
    logic             r_s1_last;
    logic [W-1:0]     r_mul_x;
    logic [W-1:0]     r_mul_y;
    logic [CNT_W-1:0] r_icnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_s1_last_nxt;

    // A last element sitting in stage 1 blocks intake until its result is consumed.
    assign in_ready      = (r_state == ACC) && !(r_s1_v && r_s1_last);
    assign w_accept      = in_valid && in_ready;
    // Vectors longer than LEN are split: element LEN is treated as last.
    assign w_s1_last_nxt = in_last || (r_icnt == CNT_W'(LEN - 1));

    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign out_valid = (r_state == DONE);
    assign out_acc   = r_acc;
    assign out_cnt   = r_cnt;

    // Stage 1: capture the operand pair onto the multiplier inputs and track position in the vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_mul_x   <= '0;
            r_mul_y   <= '0;
            r_icnt    <= '0;
        end else if (clr) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_icnt    <= '0;
        end else if (w_accept) begin
            r_mul_x   <= in_x;
            r_mul_y   <= in_y;
            r_s1_v    <= 1'b1;
            r_s1_last <= w_s1_last_nxt;
            r_icnt    <= w_s1_last_nxt ? '0 : r_icnt + CNT_W'(1);
        end else begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
        end
    end

    // Stage 2 state and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stage 2 next state: add the product in ACC, hold the result in DONE until it is taken; clr wins over everything.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        if (clr) begin
            w_state_nxt = ACC;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ACC: begin
                    if (r_s1_v) begin
                        w_acc_nxt = r_acc + ACC_W'(mul_o);
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_s1_last) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = ACC;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_dot_acc.sv
// Bench for mult_dot_acc wired to the real tree multiplier.
// Directed scenarios plus a randomized stream checked against a vector-level model.
// Inputs are driven and outputs sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_mult_dot_acc;

    localparam int W     = 4;
    localparam int LEN   = 4;
    localparam int ACC_W = 2 * W + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN + 1);

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             clr       = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b1;
    logic [W-1:0]     in_x      = '0;
    logic [W-1:0]     in_y      = '0;
    logic             in_ready;
    logic [W-1:0]     mul_x;
    logic [W-1:0]     mul_y;
    logic [2*W-1:0]   mul_o;
    logic             out_valid;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;

    int checks   = 0;
    int failures = 0;

    mult_dot_acc #(.W(W), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_o     (mul_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt)
    );

    mult_tree #(.W(W)) u_mul (
        .i_x (mul_x),
        .i_y (mul_y),
        .o_p (mul_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until the edge that accepts it.
    task automatic send(input int x, input int y, input bit last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_x     = W'(x);
        in_y     = W'(y);
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout waited=%0d cycles required<50", n);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0 || out_cnt !== '0) begin
            failures++;
            $display("FAIL reset_out valid=%0b acc=%0d cnt=%0d required 0/0/0", out_valid, out_acc, out_cnt);
        end
        checks++;
        if (mul_x !== '0 || mul_y !== '0) begin
            failures++;
            $display("FAIL reset_mul x=%0d y=%0d required 0/0", mul_x, mul_y);
        end
        #5 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
    endtask

    task automatic test_basic();
        int xs[4] = '{3, 15, 2, 1};
        int ys[4] = '{5, 15, 7, 1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_x     = W'(xs[i]);
            in_y     = W'(ys[i]);
            in_last  = (i == 3);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic_in_ready elem=%0d got=%0b required=1", i, in_ready);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (mul_x !== 4'd3 || mul_y !== 4'd5) begin
                    failures++;
                    $display("FAIL basic_mul_regs x=%0d y=%0d required 3/5", mul_x, mul_y);
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_pending valid=%0b in_ready=%0b required 0/0", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 10'd255 || out_cnt !== 3'd4) begin
            failures++;
            $display("FAIL basic_result valid=%0b acc=%0d cnt=%0d required 1/255/4", out_valid, out_acc, out_cnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_after_hs valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_implicit_last();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(15, 15, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL implicit_in_ready got=%0b required=0", in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat != 1 || out_acc !== 10'd900 || out_cnt !== 3'd4) begin
            failures++;
            $display("FAIL implicit_result lat=%0d acc=%0d cnt=%0d required 1/900/4", lat, out_acc, out_cnt);
        end
        send(15, 15, 1'b1);
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 10'd225 || out_cnt !== 3'd1) begin
            failures++;
            $display("FAIL implicit_next valid=%0b acc=%0d cnt=%0d required 1/225/1", out_valid, out_acc, out_cnt);
        end
        tick();
    endtask

    task automatic test_single();
        int lat;
        out_ready = 1'b1;
        send(0, 9, 1'b1);
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 10'd0 || out_cnt !== 3'd1) begin
            failures++;
            $display("FAIL single_result valid=%0b acc=%0d cnt=%0d required 1/0/1", out_valid, out_acc, out_cnt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(2, 3, 1'b1);
        in_valid = 1'b1;
        in_x     = 4'd1;
        in_y     = 4'd2;
        in_last  = 1'b1;
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_acc !== 10'd6 || out_cnt !== 3'd1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d valid=%0b acc=%0d cnt=%0d in_ready=%0b required 1/6/1/0",
                         i, out_valid, out_acc, out_cnt, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        send(1, 2, 1'b1);
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 10'd2 || out_cnt !== 3'd1) begin
            failures++;
            $display("FAIL stall_next valid=%0b acc=%0d cnt=%0d required 1/2/1", out_valid, out_acc, out_cnt);
        end
        tick();
    endtask

    task automatic test_clr();
        int lat;
        out_ready = 1'b1;
        send(4, 4, 1'b0);
        send(5, 5, 1'b0);
        // clr coincides with an offered last element, which must be dropped too.
        clr      = 1'b1;
        in_valid = 1'b1;
        in_x     = 4'd7;
        in_y     = 4'd7;
        in_last  = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_state valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL clr_no_output cyc=%0d valid=%0b required=0", i, out_valid);
            end
        end
        send(1, 1, 1'b1);
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 10'd1 || out_cnt !== 3'd1) begin
            failures++;
            $display("FAIL clr_next valid=%0b acc=%0d cnt=%0d required 1/1/1", out_valid, out_acc, out_cnt);
        end
        tick();
    endtask

    task automatic test_reset_in_done();
        int lat;
        out_ready = 1'b0;
        send(3, 5, 1'b0);
        send(15, 15, 1'b0);
        send(2, 7, 1'b0);
        send(1, 1, 1'b1);
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 10'd255) begin
            failures++;
            $display("FAIL rst_pre valid=%0b acc=%0d required 1/255", out_valid, out_acc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== '0 || out_cnt !== '0 || mul_x !== '0 || mul_y !== '0) begin
            failures++;
            $display("FAIL rst_async valid=%0b acc=%0d cnt=%0d mx=%0d my=%0d required all 0",
                     out_valid, out_acc, out_cnt, mul_x, mul_y);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_release in_ready=%0b valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        int ex[$];
        int ey[$];
        bit el[$];
        int exp_acc[$];
        int exp_cnt[$];
        int sum, cnt, idx, ra, cyc, len;
        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, LEN + 2);
            for (int e = 0; e < len; e++) begin
                ex.push_back($urandom_range(0, 15));
                ey.push_back($urandom_range(0, 15));
                el.push_back(e == len - 1);
            end
        end
        // Expected results: split the element stream at each last flag or every LEN elements.
        sum = 0;
        cnt = 0;
        for (int i = 0; i < ex.size(); i++) begin
            sum += ex[i] * ey[i];
            cnt++;
            if (el[i] || cnt == LEN) begin
                exp_acc.push_back(sum);
                exp_cnt.push_back(cnt);
                sum = 0;
                cnt = 0;
            end
        end
        idx = 0;
        ra  = 0;
        cyc = 0;
        while ((idx < ex.size() || ra < exp_acc.size()) && cyc < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (idx < ex.size() && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_x     = W'(ex[idx]);
                in_y     = W'(ey[idx]);
                in_last  = el[idx];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (ra >= exp_acc.size()) begin
                    failures++;
                    $display("FAIL rand_extra acc=%0d cnt=%0d required no result", out_acc, out_cnt);
                end else if (out_acc !== ACC_W'(exp_acc[ra]) || out_cnt !== CNT_W'(exp_cnt[ra])) begin
                    failures++;
                    $display("FAIL rand_result n=%0d acc=%0d cnt=%0d required %0d/%0d",
                             ra, out_acc, out_cnt, exp_acc[ra], exp_cnt[ra]);
                end
                ra++;
            end
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (idx != ex.size() || ra != exp_acc.size()) begin
            failures++;
            $display("FAIL rand_complete elems=%0d results=%0d required %0d/%0d",
                     idx, ra, ex.size(), exp_acc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_implicit_last();
        test_single();
        test_backpressure();
        test_clr();
        test_reset_in_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_dot_acc.md
Name: mult_dot_acc

Overview:
- Sequential wrapper that feeds the combinational W x W tree multiplier and consumes its 2W-bit product.
- Accepts operand pairs on a valid/ready stream and registers them onto the multiplier inputs.
- Accumulates each product into a dot-product sum and emits one result per vector on a valid/ready output.
- Gives the combinational multiplier a clean register-to-register timing path; the multiplier itself is instanced by the parent and connects through the mul_* ports.

Parameters:
- W, 4, operand width; the multiplier product is 2W bits.
- LEN, 4, maximum elements per vector (>=1).
- ACC_W, 2W+$clog2(LEN), derived localparam; accumulator width, which cannot overflow.
- CNT_W, $clog2(LEN+1), derived localparam; element count width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; highest synchronous priority.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_x  in  W  operand x.
- in_y  in  W  operand y.
- in_last  in  1  final element of the vector.
- mul_x  out  W  registered operand to the multiplier x input.
- mul_y  out  W  registered operand to the multiplier y input.
- mul_o  in  2W  multiplier product (combinational function of mul_x, mul_y).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  dot-product sum.
- out_cnt  out  CNT_W  number of elements summed.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ACC; s1_v, s1_last, mul_x, mul_y, acc, cnt and icnt are all 0.
  - Outputs: out_valid=0, out_acc=0, out_cnt=0, in_ready=1 once rst_n=1.
  - Reset asserted mid-vector or in DONE discards everything, with no partial output.
- States: ACC (collecting), DONE (holding result). Result registers drive out_acc/out_cnt; out_valid = (state==DONE).
- in_ready = (state==ACC) && !(s1_v && s1_last). No new element is taken after a last element until the result handshakes.
- Stage 1, on in_valid && in_ready:
  - mul_x<=in_x, mul_y<=in_y, s1_v<=1.
  - s1_last <= in_last || (icnt==LEN-1), an implicit last at LEN elements.
  - icnt <= s1_last_next ? 0 : icnt+1.
  - Otherwise s1_v<=0; mul_x/mul_y hold their value.
- Stage 2, in ACC with s1_v=1:
  - acc <= acc + zero-extended mul_o; cnt <= cnt+1.
  - If s1_last: state<=DONE, with acc/cnt updated on the same edge.
- Latency: the last element accepted at edge k gives out_valid=1 after edge k+1. Throughput is 1 element/cycle within a vector; a vector has 1 cycle of accept-to-result latency plus the handshake cycle.
- DONE:
  - out_acc/out_cnt are held stable while out_ready=0 (arbitrary stall length).
  - On an edge with out_ready=1: acc<=0, cnt<=0, state<=ACC.
  - in_ready is 0 throughout DONE.
- clr=1 at an edge: s1_v, acc, cnt and icnt are cleared, state<=ACC, and any pending result is dropped. clr overrides a simultaneous input accept or output handshake.
- Arithmetic: unsigned; ACC_W guarantees LEN*(2^W-1)^2 fits (900 <= 1023 at defaults).
- Empty vectors do not exist, because in_last always accompanies an element.

Decomposition:
- Shared package mult_pkg holds:
  - default W/LEN;
  - function acc_width(W,LEN);
  - state enum {ACC, DONE}.
- No internal sub-module. The tree multiplier stays a sibling instance connected via mul_x/mul_y/mul_o. The bench instances the real multiplier, not a model.

Test Plan:
- Vector (3,5),(15,15),(2,7),(1,1,last), back-to-back with out_ready=1 -> one cycle after the last accept, out_valid=1, out_acc=255, out_cnt=4; in_ready=1 otherwise.
- Five (15,15) pairs with in_last=0 -> implicit last after the fourth: out_acc=900, out_cnt=4; the fifth pair becomes element 1 of the next vector (next result out_acc=225 if it is sent with in_last).
- Single element (0,9,last) -> out_acc=0, out_cnt=1.
- Backpressure: hold out_ready=0 for 5 cycles after (2,3,last), with in_valid=1 on (1,2,last) -> out_acc=6/out_cnt=1 stable and in_ready=0 throughout. After out_ready=1 the next pair is accepted and the next out_acc=2.
- clr asserted after (4,4),(5,5) accepted -> no output; a following (1,1,last) gives out_acc=1, out_cnt=1.
- rst_n dropped asynchronously while in DONE with out_acc=255 -> out_valid, out_acc, out_cnt, mul_x and mul_y go to 0 before the next clk edge; after release, in_ready=1.
